// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: width encodings, LSU FSM states, byte-enable masks.
// Used by lsu_align and lsu_extend.
package rv32_pkg;

    localparam logic [1:0] WIDTH_BYTE    = 2'b00;
    localparam logic [1:0] WIDTH_HALF    = 2'b01;
    localparam logic [1:0] WIDTH_WORD    = 2'b10;
    localparam logic [1:0] WIDTH_ILLEGAL = 2'b11;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Byte enables across two consecutive words: [3:0] first word, [7:4] overflow word.
    function automatic logic [7:0] lane_mask(input logic [1:0] width, input logic [1:0] offset);
        logic [3:0] base;
        case (width)
            WIDTH_BYTE: base = BE_BYTE;
            WIDTH_HALF: base = BE_HALF;
            WIDTH_WORD: base = BE_WORD;
            default:    base = 4'b0000;
        endcase
        return {4'b0000, base} << offset;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] width);
        case (width)
            WIDTH_HALF: return offset[0];
            WIDTH_WORD: return offset != 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load lane extraction: shifts the two captured words down by the byte offset and
// sign/zero-extends the selected byte or halfword. Purely combinational.
module lsu_extend
    import rv32_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        usignext,
    output logic [31:0] rdata
);

    logic [63:0] merged;
    logic [31:0] lane;
    logic        sign_byte;
    logic        sign_half;

    assign merged    = {hi_word, lo_word} >> {offset, 3'b000};
    assign lane      = merged[31:0];
    assign sign_byte = ~usignext & lane[7];
    assign sign_half = ~usignext & lane[15];

    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    always_comb begin
        rdata = 32'd0;
        case (width)
            WIDTH_BYTE: rdata = {{24{sign_byte}}, lane[7:0]};
            WIDTH_HALF: rdata = {{16{sign_half}}, lane[15:0]};
            WIDTH_WORD: rdata = lane;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte/half/word requests into word-aligned memory accesses.
// Define LSU_MISALIGNED_EN to split misaligned accesses; otherwise they fault.
module lsu_align
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_usignext,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_done,
    output logic        rsp_fault,
    output logic        pause,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    lsu_state_t  state_q, state_d;

    logic        we_q;
    logic        usignext_q;
    logic        fault_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  width_q;
    logic [31:0] rbuf_q;
    logic [31:0] rdata_q;

    logic [1:0]  offset;
    logic [7:0]  lane8;
    logic        split;
    logic [63:0] wdata_wide;
    logic        req_fault;
    logic [31:0] ext_lo;
    logic [31:0] ext_rdata;

    assign offset     = addr_q[1:0];
    assign lane8      = lane_mask(width_q, offset);
    assign split      = |lane8[7:4];
    assign wdata_wide = {32'd0, wdata_q} << {offset, 3'b000};

`ifdef LSU_MISALIGNED_EN
    assign req_fault = (req_width == WIDTH_ILLEGAL);
`else
    assign req_fault = (req_width == WIDTH_ILLEGAL) | is_misaligned(req_addr[1:0], req_width);
`endif

    // The first word of a split load is parked in rbuf_q while the second word arrives.
    assign ext_lo = (state_q == ACC1) ? rbuf_q : mem_rdata;

    lsu_extend u_extend (
        .lo_word  (ext_lo),
        .hi_word  (mem_rdata),
        .offset   (offset),
        .width    (width_q),
        .usignext (usignext_q),
        .rdata    (ext_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_fault ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = lane8[3:0];
                mem_wdata = wdata_wide[31:0];
                if (mem_ready) begin
                    state_d = split ? ACC1 : RESP;
                end
            end
            ACC1: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_be    = lane8[7:4];
                mem_wdata = wdata_wide[63:32];
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: every datapath register is reset here; there is no storage array, so nothing is left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            usignext_q <= 1'b0;
            fault_q    <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            width_q    <= WIDTH_BYTE;
            rbuf_q     <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        usignext_q <= req_usignext;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        width_q    <= req_width;
                        fault_q    <= req_fault;
                        if (req_fault) begin
                            rdata_q <= 32'd0;
                        end
                    end
                end
                ACC0: begin
                    if (mem_ready) begin
                        rbuf_q <= mem_rdata;
                        if (!split && !we_q) begin
                            rdata_q <= ext_rdata;
                        end
                    end
                end
                ACC1: begin
                    if (mem_ready && !we_q) begin
                        rdata_q <= ext_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_done  = (state_q == RESP);
    assign rsp_fault = (state_q == RESP) & fault_q;
    assign pause     = ((state_q == IDLE) & req_valid) | (state_q == ACC0) | (state_q == ACC1);

endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align; expectations follow LSU_MISALIGNED_EN when defined.
`timescale 1ns/1ps
module tb_lsu_align;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_usignext;
    logic [31:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_done;
    logic        rsp_fault;
    logic        pause;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    lsu_align dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_width    (req_width),
        .req_usignext (req_usignext),
        .req_wdata    (req_wdata),
        .rsp_rdata    (rsp_rdata),
        .rsp_done     (rsp_done),
        .rsp_fault    (rsp_fault),
        .pause        (pause),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted memory accesses.
    always @(posedge clk) begin
        if (mem_valid && mem_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] width,
                         input logic usx, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_width    = width;
        req_usignext = usx;
        req_wdata    = wdata;
    endtask

    // Single aligned access with mem_ready=1: mem access in N+1, rsp_done in N+2.
    task automatic one_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [1:0] width, input logic usx, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata);
        int a0;
        @(negedge clk);
        a0 = acc_cnt;
        issue(we, addr, width, usx, wdata);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        #1;
        check({tag, "/N_pause"}, 32'(pause), 32'd1);
        check({tag, "/N_memvalid"}, 32'(mem_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "/memvalid"}, 32'(mem_valid), 32'd1);
        check({tag, "/memwe"}, 32'(mem_we), 32'(we));
        check({tag, "/addr"}, mem_addr, exp_addr);
        check({tag, "/be"}, 32'(mem_be), 32'(exp_be));
        if (we) check({tag, "/wdata"}, mem_wdata, exp_wdata);
        check({tag, "/early_done"}, 32'(rsp_done), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, "/done"}, 32'(rsp_done), 32'd1);
        check({tag, "/fault"}, 32'(rsp_fault), 32'd0);
        check({tag, "/resp_pause"}, 32'(pause), 32'd0);
        check({tag, "/resp_memvalid"}, 32'(mem_valid), 32'd0);
        check({tag, "/nacc"}, 32'(acc_cnt - a0), 32'd1);
        if (!we) check({tag, "/rdata"}, rsp_rdata, exp_rdata);
        @(negedge clk);
        #1;
        check({tag, "/done_pulse"}, 32'(rsp_done), 32'd0);
        if (!we) check({tag, "/rdata_held"}, rsp_rdata, exp_rdata);
    endtask

    // Request that must fault straight from IDLE without touching memory.
    task automatic fault_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [1:0] width);
        int a0;
        @(negedge clk);
        a0 = acc_cnt;
        issue(we, addr, width, 1'b0, 32'hCAFEF00D);
        mem_ready = 1'b1;
        #1;
        check({tag, "/N_pause"}, 32'(pause), 32'd1);
        check({tag, "/N_memvalid"}, 32'(mem_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, "/done"}, 32'(rsp_done), 32'd1);
        check({tag, "/fault"}, 32'(rsp_fault), 32'd1);
        check({tag, "/rdata"}, rsp_rdata, 32'd0);
        check({tag, "/memvalid"}, 32'(mem_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "/done_pulse"}, 32'(rsp_done), 32'd0);
        check({tag, "/fault_pulse"}, 32'(rsp_fault), 32'd0);
        check({tag, "/nacc"}, 32'(acc_cnt - a0), 32'd0);
    endtask

    initial begin
        int a0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_width    = 2'b00;
        req_usignext = 1'b0;
        req_wdata    = 32'd0;
        mem_rdata    = 32'd0;
        mem_ready    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst/memvalid", 32'(mem_valid), 32'd0);
        check("rst/done", 32'(rsp_done), 32'd0);
        check("rst/fault", 32'(rsp_fault), 32'd0);
        check("rst/pause", 32'(pause), 32'd0);
        check("rst/rdata", rsp_rdata, 32'd0);
        check("rst/be", 32'(mem_be), 32'd0);
        reset = 1'b0;

        one_access("lw_aligned", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'd0,
                   32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        one_access("lb_signed", 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'd0,
                   32'h8012_3456, 32'h0000_0100, 4'b1000, 32'd0, 32'hFFFF_FF80);
        one_access("lbu", 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'd0,
                   32'h8012_3456, 32'h0000_0100, 4'b1000, 32'd0, 32'h0000_0080);
        one_access("lh_off2", 1'b0, 32'h0000_0102, 2'b01, 1'b0, 32'd0,
                   32'hABCD_0000, 32'h0000_0100, 4'b1100, 32'd0, 32'hFFFF_ABCD);
        one_access("sb_off1", 1'b1, 32'h0000_0201, 2'b00, 1'b0, 32'h0000_0055,
                   32'd0, 32'h0000_0200, 4'b0010, 32'h0000_5500, 32'd0);

        // Memory holds off for five cycles.
        @(negedge clk);
        a0 = acc_cnt;
        issue(1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("wait/memvalid", 32'(mem_valid), 32'd1);
            check("wait/pause", 32'(pause), 32'd1);
            check("wait/done", 32'(rsp_done), 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check("wait/memvalid_last", 32'(mem_valid), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("wait/done_end", 32'(rsp_done), 32'd1);
        check("wait/rdata", rsp_rdata, 32'h1234_5678);
        check("wait/nacc", 32'(acc_cnt - a0), 32'd1);

        fault_req("illegal_width", 1'b0, 32'h0000_0100, 2'b11);

`ifdef LSU_MISALIGNED_EN
        one_access("lh_off1", 1'b0, 32'h0000_0101, 2'b01, 1'b0, 32'd0,
                   32'h00BE_EF00, 32'h0000_0100, 4'b0110, 32'd0, 32'hFFFF_BEEF);

        // Split store word at offset 2.
        @(negedge clk);
        a0 = acc_cnt;
        issue(1'b1, 32'h0000_0102, 2'b10, 1'b0, 32'h1122_3344);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("sw_split/addr0", mem_addr, 32'h0000_0100);
        check("sw_split/be0", 32'(mem_be), 32'(4'b1100));
        check("sw_split/wdata0", mem_wdata, 32'h3344_0000);
        @(negedge clk);
        #1;
        check("sw_split/addr1", mem_addr, 32'h0000_0104);
        check("sw_split/be1", 32'(mem_be), 32'(4'b0011));
        check("sw_split/wdata1", mem_wdata, 32'h0000_1122);
        check("sw_split/early_done", 32'(rsp_done), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("sw_split/done", 32'(rsp_done), 32'd1);
        check("sw_split/nacc", 32'(acc_cnt - a0), 32'd2);

        // Split load word at offset 3.
        @(negedge clk);
        issue(1'b0, 32'h0000_0103, 2'b10, 1'b0, 32'd0);
        @(negedge clk);
        mem_rdata = 32'hAA00_0000;
        @(negedge clk);
        mem_rdata = 32'h00CC_BBDD;
        #1;
        check("lw_split/be1", 32'(mem_be), 32'(4'b0111));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("lw_split/rdata", rsp_rdata, 32'hCCBB_DDAA);

        // Half at 0xFFFFFFFF wraps; reset lands in ACC1.
        @(negedge clk);
        issue(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        check("wrap/addr0", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("wrap/addr1", mem_addr, 32'h0000_0000);
        check("wrap/be1", 32'(mem_be), 32'(4'b0001));
        @(negedge clk);
        #1;
        check("rst_acc1/memvalid", 32'(mem_valid), 32'd0);
        check("rst_acc1/done", 32'(rsp_done), 32'd0);
        check("rst_acc1/pause", 32'(pause), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b1;
`else
        fault_req("lh_misaligned", 1'b0, 32'h0000_0101, 2'b01);
        fault_req("sw_misaligned", 1'b1, 32'h0000_0102, 2'b10);
`endif

        // Reset during ACC0 aborts the access.
        @(negedge clk);
        issue(1'b0, 32'h0000_0400, 2'b10, 1'b0, 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_acc0/memvalid_before", 32'(mem_valid), 32'd1);
        @(negedge clk);
        #1;
        check("rst_acc0/memvalid", 32'(mem_valid), 32'd0);
        check("rst_acc0/done", 32'(rsp_done), 32'd0);
        check("rst_acc0/rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_acc0/idle_done", 32'(rsp_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
